term_tx_port: RTL and testbench

TERM_TX_PORT -- requirements
Module: term_tx_port

---
 rtl/term_tx_port.sv | 146 ++++++++++++++
 tb/tb_term_tx_port.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/term_tx_port.sv
// -----------------------------------------------------------------------------
// term_tx_port
//   Terminal transmit port of a mesh NoC node. The local device pushes packets
//   (destination row/column, routing mode, payload) into a small show-ahead
//   FIFO. The head packet is presented to the router, which consumes it with
//   popin. Pushes with an illegal destination or into a full FIFO are dropped
//   and reported through sticky flags.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   push                : enqueue request (dst_row, dst_col, mode, payload)
//   full                : FIFO holds fifo_depth packets
//   data_out_i_in       : head packet toward router (all-zero when empty)
//   pndng_i_in          : head packet valid
//   popin               : router consumed the head packet
//   ovf                 : sticky, a legal push was dropped because full
//   bad_dst             : sticky, a push was dropped for illegal destination
//   tx_cnt              : packets consumed by the router, wraps at 16 bits
//
// Packet layout (MSB first):
//   [8'h00 next-jump][dst_row:4][dst_col:4][mode:1][payload:pckg_sz-17]
// -----------------------------------------------------------------------------
module term_tx_port #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4,
    parameter int ROWS       = 4,
    parameter int COLUMS     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [3:0]         dst_row,
    input  logic [3:0]         dst_col,
    input  logic               mode,
    input  logic [pckg_sz-18:0] payload,
    output logic               full,
    output logic [pckg_sz-1:0] data_out_i_in,
    output logic               pndng_i_in,
    input  logic               popin,
    output logic               ovf,
    output logic               bad_dst,
    output logic [15:0]        tx_cnt
);

    localparam int AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH    = CW'(fifo_depth);
    localparam logic [31:0]   ROWS_MAX = 32'(ROWS);
    localparam logic [31:0]   COLS_MAX = 32'(COLUMS);

    // Storage and control state
    logic [pckg_sz-1:0] mem_q [fifo_depth];
    logic [pckg_sz-1:0] mem_d [fifo_depth];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               pndng_q, pndng_d;
    logic               full_q, full_d;
    logic               ovf_q, ovf_d;
    logic               bad_dst_q, bad_dst_d;
    logic [15:0]        tx_cnt_q, tx_cnt_d;

    logic               dst_ok;
    logic               pop_acc;
    logic               push_acc;
    logic [pckg_sz-1:0] pkt;
    logic [31:0]        row_w, col_w;

    always_comb begin
        row_w  = {28'd0, dst_row};
        col_w  = {28'd0, dst_col};
        dst_ok = (row_w >= 32'd1) && (row_w <= ROWS_MAX) &&
                 (col_w >= 32'd1) && (col_w <= COLS_MAX);

        // popin on an empty FIFO is simply ignored.
        pop_acc  = popin & pndng_q;
        // A pop in the same edge frees the slot, so a full FIFO can still
        // accept a push when the router drains it simultaneously.
        push_acc = push & dst_ok & (~full_q | pop_acc);

        pkt = {8'h00, dst_row, dst_col, mode, payload};

        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        tx_cnt_d  = tx_cnt_q;
        ovf_d     = ovf_q;
        bad_dst_d = bad_dst_q;

        if (push_acc) begin
            mem_d[wr_ptr_q] = pkt;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            tx_cnt_d = tx_cnt_q + 16'd1;
        end

        count_d = count_q + {{(CW-1){1'b0}}, push_acc} - {{(CW-1){1'b0}}, pop_acc};

        // Destination check wins over the full check: an illegal push while
        // full flags bad_dst only.
        if (push && !dst_ok)
            bad_dst_d = 1'b1;
        if (push && dst_ok && full_q && !pop_acc)
            ovf_d = 1'b1;

        // Status flags are registered from the next count so that neither
        // depends combinationally on push or popin.
        pndng_d = (count_d != '0);
        full_d  = (count_d == DEPTH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pndng_q   <= 1'b0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bad_dst_q <= 1'b0;
            tx_cnt_q  <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pndng_q   <= pndng_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            bad_dst_q <= bad_dst_d;
            tx_cnt_q  <= tx_cnt_d;
        end
    end

    // Show-ahead head; masked so the bus reads zero whenever nothing is pending.
    assign data_out_i_in = pndng_q ? mem_q[rd_ptr_q] : '0;
    assign pndng_i_in    = pndng_q;
    assign full          = full_q;
    assign ovf           = ovf_q;
    assign bad_dst       = bad_dst_q;
    assign tx_cnt        = tx_cnt_q;

endmodule

// File: tb/tb_term_tx_port.sv
// -----------------------------------------------------------------------------
// tb_term_tx_port
//   Directed bench for term_tx_port. The stimulus process pushes the expected
//   packet into a scoreboard queue whenever it issues a push that must be
//   accepted; a negedge monitor pops and compares whenever the DUT presents a
//   head packet that the router is consuming. Status outputs are checked
//   directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_term_tx_port;

    localparam int PSZ = 40;
    localparam int PLW = PSZ - 17;

    logic           clk;
    logic           reset;
    logic           push;
    logic [3:0]     dst_row;
    logic [3:0]     dst_col;
    logic           mode;
    logic [PLW-1:0] payload;
    logic           full;
    logic [PSZ-1:0] data_out_i_in;
    logic           pndng_i_in;
    logic           popin;
    logic           ovf;
    logic           bad_dst;
    logic [15:0]    tx_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [PSZ-1:0] sbq [$];

    term_tx_port #(
        .pckg_sz(PSZ), .fifo_depth(4), .ROWS(4), .COLUMS(4)
    ) dut (
        .clk(clk), .reset(reset), .push(push), .dst_row(dst_row),
        .dst_col(dst_col), .mode(mode), .payload(payload), .full(full),
        .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in), .popin(popin),
        .ovf(ovf), .bad_dst(bad_dst), .tx_cnt(tx_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PSZ-1:0] pack(input logic [3:0] r, input logic [3:0] c,
                                            input logic m, input logic [PLW-1:0] p);
        return {8'h00, r, c, m, p};
    endfunction

    // One clock of stimulus. acc says whether the push must be accepted.
    task automatic cyc(input bit p, input logic [3:0] r, input logic [3:0] c,
                       input bit m, input logic [PLW-1:0] pl, input bit pp, input bit acc);
        push    = p;
        dst_row = r;
        dst_col = c;
        mode    = m;
        payload = pl;
        popin   = pp;
        if (acc) sbq.push_back(pack(r, c, m, pl));
        @(posedge clk);
        #1;
        push  = 1'b0;
        popin = 1'b0;
    endtask

    task automatic pop1();
        cyc(1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sbq.delete();
        #2;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Scoreboard monitor: sample mid-cycle, inputs are stable until next posedge.
    always @(negedge clk) begin
        if (!reset) begin
            if (pndng_i_in) begin
                if (popin) begin
                    if (sbq.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL pop_unexpected: got %h expected none at %0t", data_out_i_in, $time);
                    end else begin
                        chk("pop_data", 64'(data_out_i_in), 64'(sbq.pop_front()));
                    end
                end
            end else begin
                chk("empty_zero", 64'(data_out_i_in), 64'd0);
            end
        end
    end

    initial begin
        reset   = 1'b1;
        push    = 1'b0;
        popin   = 1'b0;
        dst_row = '0;
        dst_col = '0;
        mode    = 1'b0;
        payload = '0;

        // Reset state
        #2;
        chk("rst_pndng", 64'(pndng_i_in), 64'd0);
        chk("rst_full",  64'(full), 64'd0);
        chk("rst_ovf",   64'(ovf), 64'd0);
        chk("rst_bad",   64'(bad_dst), 64'd0);
        chk("rst_tx",    64'(tx_cnt), 64'd0);
        chk("rst_data",  64'(data_out_i_in), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single push into empty FIFO, hand-packed layout
        cyc(1'b1, 4'd2, 4'd3, 1'b1, 23'h00ABCD, 1'b0, 1'b1);
        chk("t1_pndng", 64'(pndng_i_in), 64'd1);
        chk("t1_data",  64'(data_out_i_in), 64'h00_2380ABCD);
        pop1();
        chk("t1_empty", 64'(pndng_i_in), 64'd0);
        chk("t1_tx",    64'(tx_cnt), 64'd1);

        // Fill, overflow, illegal-while-full, then drain in order
        do_reset();
        cyc(1'b1, 4'd1, 4'd1, 1'b0, 23'h000001, 1'b0, 1'b1);
        cyc(1'b1, 4'd2, 4'd2, 1'b1, 23'h000002, 1'b0, 1'b1);
        cyc(1'b1, 4'd3, 4'd3, 1'b0, 23'h000003, 1'b0, 1'b1);
        chk("t2_notfull", 64'(full), 64'd0);
        cyc(1'b1, 4'd4, 4'd4, 1'b1, 23'h000004, 1'b0, 1'b1);
        chk("t2_full",  64'(full), 64'd1);
        chk("t2_ovf0",  64'(ovf), 64'd0);
        cyc(1'b1, 4'd0, 4'd2, 1'b0, 23'h0000EE, 1'b0, 1'b0);
        chk("t2_bad_prio", 64'(bad_dst), 64'd1);
        chk("t2_ovf_prio", 64'(ovf), 64'd0);
        cyc(1'b1, 4'd1, 4'd2, 1'b0, 23'h000005, 1'b0, 1'b0);
        chk("t2_ovf",   64'(ovf), 64'd1);
        chk("t2_full2", 64'(full), 64'd1);
        for (int i = 0; i < 4; i++) pop1();
        chk("t2_empty", 64'(pndng_i_in), 64'd0);
        chk("t2_tx",    64'(tx_cnt), 64'd4);
        chk("t2_ovf_sticky", 64'(ovf), 64'd1);

        // Push and pop together at full
        do_reset();
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 4'd1, 4'(i + 1), 1'b0, 23'(16 + i), 1'b0, 1'b1);
        cyc(1'b1, 4'd3, 4'd1, 1'b1, 23'h7FFFFF, 1'b1, 1'b1);
        chk("t3_full", 64'(full), 64'd1);
        chk("t3_ovf",  64'(ovf), 64'd0);
        for (int i = 0; i < 4; i++) pop1();
        chk("t3_empty", 64'(pndng_i_in), 64'd0);
        chk("t3_tx",    64'(tx_cnt), 64'd5);

        // Push and pop together at count = 1
        do_reset();
        cyc(1'b1, 4'd2, 4'd1, 1'b0, 23'h000A0A, 1'b0, 1'b1);
        cyc(1'b1, 4'd1, 4'd4, 1'b1, 23'h000B0B, 1'b1, 1'b1);
        chk("t4_pndng", 64'(pndng_i_in), 64'd1);
        chk("t4_head",  64'(data_out_i_in), 64'(pack(4'd1, 4'd4, 1'b1, 23'h000B0B)));
        pop1();
        chk("t4_empty", 64'(pndng_i_in), 64'd0);

        // Illegal destinations, pop while empty, legal boundary destinations
        do_reset();
        cyc(1'b1, 4'd2, 4'd0, 1'b0, 23'h000111, 1'b0, 1'b0);
        chk("t5_bad_col", 64'(bad_dst), 64'd1);
        cyc(1'b1, 4'd5, 4'd2, 1'b0, 23'h000222, 1'b0, 1'b0);
        chk("t5_pndng", 64'(pndng_i_in), 64'd0);
        pop1();
        chk("t5_tx0",   64'(tx_cnt), 64'd0);
        chk("t5_ovf",   64'(ovf), 64'd0);
        cyc(1'b1, 4'd1, 4'd1, 1'b0, 23'h000333, 1'b0, 1'b1);
        cyc(1'b1, 4'd4, 4'd4, 1'b1, 23'h000444, 1'b0, 1'b1);
        pop1();
        pop1();
        chk("t5_tx2",   64'(tx_cnt), 64'd2);
        chk("t5_bad_sticky", 64'(bad_dst), 64'd1);

        // Asynchronous reset mid-transfer, push held during reset is ignored
        do_reset();
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 4'd3, 4'd3, 1'b0, 23'(32 + i), 1'b0, 1'b1);
        pop1();
        chk("t6_pre_full", 64'(full), 64'd0);
        cyc(1'b1, 4'd2, 4'd2, 1'b0, 23'h000055, 1'b0, 1'b1);
        chk("t6_pre_full2", 64'(full), 64'd1);
        #2;
        reset = 1'b1;
        sbq.delete();
        #1;
        chk("t6_async_pndng", 64'(pndng_i_in), 64'd0);
        chk("t6_async_tx",    64'(tx_cnt), 64'd0);
        chk("t6_async_full",  64'(full), 64'd0);
        chk("t6_async_data",  64'(data_out_i_in), 64'd0);
        push    = 1'b1;
        dst_row = 4'd1;
        dst_col = 4'd1;
        @(posedge clk);
        #1;
        push  = 1'b0;
        reset = 1'b0;
        chk("t6_no_push_in_rst", 64'(pndng_i_in), 64'd0);
        cyc(1'b1, 4'd2, 4'd3, 1'b1, 23'h00ABCD, 1'b0, 1'b1);
        chk("t6_data", 64'(data_out_i_in), 64'h00_2380ABCD);
        pop1();

        // tx_cnt wrap: 65537 accepted pops
        do_reset();
        for (int i = 0; i < 65537; i++)
            cyc(1'b1, 4'(1 + (i % 4)), 4'(1 + ((i / 4) % 4)), 1'(i), 23'(i), 1'b1, 1'b1);
        pop1();
        chk("t7_tx_wrap", 64'(tx_cnt), 64'd1);
        chk("t7_empty",   64'(pndng_i_in), 64'd0);
        chk("t7_sb_drained", 64'(sbq.size()), 64'd0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
